// File: rtl/ff_edge_pkg.sv
// rtl/ff_edge_pkg.sv - shared defaults and width helper for the flip-flop edge logger.
// Timestamp width only matters when FF_EDGE_TS_EN is defined.
package ff_edge_pkg;

  localparam int DEFAULT_INPUT_WIDTH = 4;
  localparam int DEFAULT_FIFO_DEPTH  = 4;
  localparam int DEFAULT_TS_WIDTH    = 8;

  // Occupancy counter must hold DEPTH itself, hence one bit beyond the pointer width.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ff_edge_logger_if.sv
// rtl/ff_edge_logger_if.sv - event record stream between logger and consumer.
// Carries evt_ts only when FF_EDGE_TS_EN is defined.
interface ff_edge_logger_if #(
  parameter int INPUT_WIDTH = ff_edge_pkg::DEFAULT_INPUT_WIDTH,
  parameter int FIFO_DEPTH  = ff_edge_pkg::DEFAULT_FIFO_DEPTH,
  parameter int TS_WIDTH    = ff_edge_pkg::DEFAULT_TS_WIDTH,
  parameter int COUNT_WIDTH = ff_edge_pkg::count_width(FIFO_DEPTH)
);

  logic                   evt_valid;
  logic                   evt_ready;
  logic [INPUT_WIDTH-1:0] evt_mask;
  logic [INPUT_WIDTH-1:0] evt_value;
  logic [COUNT_WIDTH-1:0] evt_count;
`ifdef FF_EDGE_TS_EN
  logic [TS_WIDTH-1:0]    evt_ts;
`endif

  modport master (
    output evt_valid, evt_mask, evt_value, evt_count,
`ifdef FF_EDGE_TS_EN
    output evt_ts,
`endif
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_mask, evt_value, evt_count,
`ifdef FF_EDGE_TS_EN
    input  evt_ts,
`endif
    output evt_ready
  );

endinterface

// File: rtl/ff_edge_fifo.sv
// rtl/ff_edge_fifo.sv - generic power-of-two FIFO with push/pop, occupancy count and full flag.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module ff_edge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count=0 after reset hides every stale entry.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ff_edge_logger.sv
// rtl/ff_edge_logger.sv - logs changes of a flip-flop bank output into an event FIFO.
// Define FF_EDGE_TS_EN to attach a free-running timestamp to each record.
module ff_edge_logger #(
  parameter int INPUT_WIDTH = ff_edge_pkg::DEFAULT_INPUT_WIDTH,
  parameter int FIFO_DEPTH  = ff_edge_pkg::DEFAULT_FIFO_DEPTH,
  parameter int TS_WIDTH    = ff_edge_pkg::DEFAULT_TS_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [INPUT_WIDTH-1:0] q_in,
  input  logic                   en,
  output logic                   ovf,
  input  logic                   ovf_clr,
  ff_edge_logger_if.master       evt
);

  import ff_edge_pkg::*;

  localparam int CW = count_width(FIFO_DEPTH);
`ifdef FF_EDGE_TS_EN
  localparam int REC_W = 2 * INPUT_WIDTH + TS_WIDTH;
`else
  localparam int REC_W = 2 * INPUT_WIDTH;
`endif

  logic [INPUT_WIDTH-1:0] prev;
  logic                   primed;
  logic                   push_req;
  logic                   pop_req;
  logic                   overflow;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [REC_W-1:0]       wdata;
  logic [REC_W-1:0]       rdata;
  logic [CW-1:0]          count;

  assign push_req = primed && en && (q_in != prev);
  assign pop_req  = evt.evt_valid && evt.evt_ready;
  assign overflow = push_req && fifo_full && !pop_req;

`ifdef FF_EDGE_TS_EN
  logic [TS_WIDTH-1:0] ts;

  // The record carries the counter value of its creation edge, before increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ts <= '0;
    else       ts <= ts + TS_WIDTH'(1);
  end

  assign wdata      = {ts, q_in ^ prev, q_in};
  assign evt.evt_ts = rdata[REC_W-1 -: TS_WIDTH];
`else
  assign wdata = {q_in ^ prev, q_in};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev   <= '0;
      primed <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      prev   <= q_in;
      primed <= 1'b1;
      if (overflow)     ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  ff_edge_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_req),
    .pop   (pop_req),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_count = count;
  assign evt.evt_mask  = rdata[2*INPUT_WIDTH-1 -: INPUT_WIDTH];
  assign evt.evt_value = rdata[INPUT_WIDTH-1:0];

endmodule
